// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types, opcodes and IR field positions for the control sequencer
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_HALT  = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SHR  = 4'd3,
        ALU_SHRA = 4'd4,
        ALU_SHL  = 4'd5,
        ALU_ROR  = 4'd6,
        ALU_ROL  = 4'd7,
        ALU_AND  = 4'd8,
        ALU_OR   = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_INC  = 4'd11
    } alu_op_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    // Register-register ALU opcodes only; MUL is sequenced separately.
    function automatic alu_op_t alu_of_opcode(input logic [4:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_SHR:  return ALU_SHR;
            OP_SHRA: return ALU_SHRA;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_ROL:  return ALU_ROL;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - 4-bit register index plus enable to one-hot select
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    assign onehot = en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute sequencer driving datapath strobes
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IR_W     = 32
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic [IR_W-1:0]     IR,
    input  logic                Stop,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                LOin,
    output logic                HIin,
    output alu_op_t             ALU_op,
    output logic                Run,
    output logic                Illegal,
    output logic [3:0]          State
);

    state_t     state, state_nxt;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       op_alu, op_mul, op_halt, op_known, last_step;
    logic       rin_en, rout_en;
    logic [3:0] rin_idx, rout_idx;
    logic       unused_ir;

    assign opc       = IR[OPC_MSB:OPC_LSB];
    assign ra        = IR[RA_MSB:RA_LSB];
    assign rb        = IR[RB_MSB:RB_LSB];
    assign rc        = IR[RC_MSB:RC_LSB];
    assign unused_ir = ^IR[RC_LSB-1:0];

    assign op_alu   = (alu_of_opcode(opc) != ALU_NOP);
    assign op_mul   = (opc == OP_MUL);
    assign op_halt  = (opc == OP_HALT);
    assign op_known = op_alu | op_mul | op_halt | (opc == OP_NOP);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= ST_RESET;
        else         state <= state_nxt;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)                           Illegal <= 1'b0;
        else if (state == ST_T3 && !op_known)  Illegal <= 1'b1;
    end

    always_comb begin
        state_nxt = state;
        last_step = 1'b0;
        case (state)
            ST_RESET: state_nxt = ST_T0;
            ST_T0:    state_nxt = ST_T1;
            ST_T1:    state_nxt = ST_T2;
            ST_T2:    state_nxt = ST_T3;
            ST_T3: begin
                if (op_halt)               state_nxt = ST_HALT;
                else if (op_alu || op_mul) state_nxt = ST_T4;
                else                       last_step = 1'b1;
            end
            ST_T4:    state_nxt = ST_T5;
            ST_T5: begin
                if (op_mul) state_nxt = ST_T6;
                else        last_step = 1'b1;
            end
            ST_T6:    last_step = 1'b1;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RESET;
        endcase
        // Stop only matters on the edge that ends an instruction.
        if (last_step) state_nxt = Stop ? ST_HALT : ST_T0;
    end

    always_comb begin
        {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin} = '0;
        {Yin, Zin, ZLOout, ZHIout, LOin, HIin}                 = '0;
        ALU_op   = ALU_NOP;
        rin_en   = 1'b0;
        rin_idx  = ra;
        rout_en  = 1'b0;
        rout_idx = rb;
        Run      = (state != ST_RESET) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                ALU_op = ALU_INC;
            end
            ST_T1: begin
                ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (op_alu || op_mul) begin
                    rout_en = 1'b1; Yin = 1'b1;
                end
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                Zin      = 1'b1;
                ALU_op   = op_mul ? ALU_MUL : alu_of_opcode(opc);
            end
            ST_T5: begin
                ZLOout = 1'b1;
                if (op_mul) LOin   = 1'b1;
                else        rin_en = 1'b1;
            end
            ST_T6: begin
                ZHIout = 1'b1; HIin = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = state;

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .idx    (rin_idx),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Stop = 1'b0;
    logic [31:0] IR = '0;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, ZLOout, ZHIout, LOin, HIin;
    alu_op_t     ALU_op;
    logic        Run, Illegal;
    logic [3:0]  State;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    control_sequencer #(.NUM_REGS(16), .IR_W(32)) dut (
        .Clock(Clock), .Resetn(Resetn), .IR(IR), .Stop(Stop),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLOout(ZLOout), .ZHIout(ZHIout), .LOin(LOin), .HIin(HIin),
        .ALU_op(ALU_op), .Run(Run), .Illegal(Illegal), .State(State)
    );

    wire [13:0] strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                        Yin, Zin, ZLOout, ZHIout, LOin, HIin};

    localparam logic [13:0] B_PCOUT = 14'h2000, B_PCIN  = 14'h1000, B_INCPC = 14'h0800;
    localparam logic [13:0] B_MARIN = 14'h0400, B_READ  = 14'h0200, B_MDRIN = 14'h0100;
    localparam logic [13:0] B_MDROUT = 14'h0080, B_IRIN = 14'h0040, B_YIN   = 14'h0020;
    localparam logic [13:0] B_ZIN   = 14'h0010, B_ZLO   = 14'h0008, B_ZHI   = 14'h0004;
    localparam logic [13:0] B_LOIN  = 14'h0002, B_HIIN  = 14'h0001;
    localparam logic [13:0] F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [13:0] F1 = B_ZLO | B_PCIN | B_READ | B_MDRIN;
    localparam logic [13:0] F2 = B_MDROUT | B_IRIN;

    typedef struct {
        state_t      st;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [13:0] strb;
        alu_op_t     alu;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        logic        stop;
        logic        ill;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];
    exp_t q[$];

    function automatic exp_t mk(state_t st, logic [15:0] rin, logic [15:0] rout,
                                logic [13:0] s, alu_op_t alu);
        exp_t e;
        e.st = st; e.rin = rin; e.rout = rout; e.strb = s; e.alu = alu;
        return e;
    endfunction

    function automatic vec_t v(logic [31:0] ir, logic stop, logic ill, exp_t e);
        vec_t r;
        r.ir = ir; r.stop = stop; r.ill = ill; r.e = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_inv();
        int bus;
        bus = int'(Rout != 0) + int'(PCout) + int'(MDRout) + int'(ZLOout) + int'(ZHIout);
        chk("inv_rout_onehot", 32'($countones(Rout) <= 1), 32'd1);
        chk("inv_bus_single", 32'(bus <= 1), 32'd1);
    endtask

    task automatic chk_exp(input string tag, input exp_t e, input logic ill);
        chk({tag, "_state"}, 32'(State), 32'(e.st));
        chk({tag, "_rin"}, 32'(Rin), 32'(e.rin));
        chk({tag, "_rout"}, 32'(Rout), 32'(e.rout));
        chk({tag, "_strb"}, 32'(strb), 32'(e.strb));
        chk({tag, "_alu"}, 32'(ALU_op), 32'(e.alu));
        chk({tag, "_run"}, 32'(Run), 32'((e.st != ST_RESET) && (e.st != ST_HALT)));
        chk({tag, "_illegal"}, 32'(Illegal), 32'(ill));
        chk_inv();
    endtask

    // Apply inputs for the current state, compare, then advance one edge.
    task automatic step(input string tag, input logic [31:0] ir, input logic stop,
                        input exp_t e, input logic ill);
        IR = ir;
        Stop = stop;
        #1;
        chk_exp(tag, e, ill);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        #2;
        chk_exp("rst", mk(ST_RESET, 0, 0, 0, ALU_NOP), 1'b0);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    function automatic int kind(logic [4:0] opc);
        if (opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                        5'b01000, 5'b01001, 5'b01010, 5'b01011}) return 1;
        if (opc == 5'b01111) return 2;
        if (opc == 5'b11010) return 3;
        if (opc == 5'b11011) return 4;
        return 0;
    endfunction

    function automatic alu_op_t exp_alu(logic [4:0] opc);
        case (opc)
            5'b00011: return ALU_ADD;
            5'b00100: return ALU_SUB;
            5'b00101: return ALU_SHR;
            5'b00110: return ALU_SHRA;
            5'b00111: return ALU_SHL;
            5'b01000: return ALU_ROR;
            5'b01001: return ALU_AND;
            5'b01010: return ALU_OR;
            5'b01011: return ALU_ROL;
            5'b01111: return ALU_MUL;
            default:  return ALU_NOP;
        endcase
    endfunction

    task automatic build(input logic [31:0] ir);
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        opc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        q.delete();
        q.push_back(mk(ST_T0, 0, 0, F0, ALU_INC));
        q.push_back(mk(ST_T1, 0, 0, F1, ALU_NOP));
        q.push_back(mk(ST_T2, 0, 0, F2, ALU_NOP));
        if (kind(opc) == 1 || kind(opc) == 2) begin
            q.push_back(mk(ST_T3, 0, 16'(1) << rb, B_YIN, ALU_NOP));
            q.push_back(mk(ST_T4, 0, 16'(1) << rc, B_ZIN, exp_alu(opc)));
            if (kind(opc) == 1) begin
                q.push_back(mk(ST_T5, 16'(1) << ra, 0, B_ZLO, ALU_NOP));
            end else begin
                q.push_back(mk(ST_T5, 0, 0, B_ZLO | B_LOIN, ALU_NOP));
                q.push_back(mk(ST_T6, 0, 0, B_ZHI | B_HIIN, ALU_NOP));
            end
        end else begin
            q.push_back(mk(ST_T3, 0, 0, 0, ALU_NOP));
        end
    endtask

    task automatic push_fetch(input logic [31:0] ir, input logic ill);
        tbl.push_back(v(ir, 1'b0, ill, mk(ST_T0, 0, 0, F0, ALU_INC)));
        tbl.push_back(v(ir, 1'b0, ill, mk(ST_T1, 0, 0, F1, ALU_NOP)));
        tbl.push_back(v(ir, 1'b0, ill, mk(ST_T2, 0, 0, F2, ALU_NOP)));
    endtask

    logic [4:0] ops [16] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                             5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b11010, 5'b11011,
                             5'b00000, 5'b01100, 5'b10000, 5'b11111};

    initial begin
        exp_t  halt_e;
        logic  model_ill;
        logic  last_stop;
        logic [31:0] r;
        logic [31:0] ir;
        logic [4:0]  opc;

        halt_e = mk(ST_HALT, 0, 0, 0, ALU_NOP);

        // Directed table: AND, MUL, NOP, illegal, ADD, AND with Stop, HALT hold
        push_fetch(32'h48918000, 1'b0);
        tbl.push_back(v(32'h48918000, 0, 0, mk(ST_T3, 0, 16'h0004, B_YIN, ALU_NOP)));
        tbl.push_back(v(32'h48918000, 0, 0, mk(ST_T4, 0, 16'h0008, B_ZIN, ALU_AND)));
        tbl.push_back(v(32'h48918000, 0, 0, mk(ST_T5, 16'h0002, 0, B_ZLO, ALU_NOP)));
        push_fetch(32'h78118000, 1'b0);
        tbl.push_back(v(32'h78118000, 0, 0, mk(ST_T3, 0, 16'h0004, B_YIN, ALU_NOP)));
        tbl.push_back(v(32'h78118000, 0, 0, mk(ST_T4, 0, 16'h0008, B_ZIN, ALU_MUL)));
        tbl.push_back(v(32'h78118000, 0, 0, mk(ST_T5, 0, 0, B_ZLO | B_LOIN, ALU_NOP)));
        tbl.push_back(v(32'h78118000, 0, 0, mk(ST_T6, 0, 0, B_ZHI | B_HIIN, ALU_NOP)));
        push_fetch(32'hD0000000, 1'b0);
        tbl.push_back(v(32'hD0000000, 0, 0, mk(ST_T3, 0, 0, 0, ALU_NOP)));
        push_fetch(32'hF8000000, 1'b0);
        tbl.push_back(v(32'hF8000000, 0, 0, mk(ST_T3, 0, 0, 0, ALU_NOP)));
        push_fetch(32'h18918000, 1'b1);
        tbl.push_back(v(32'h18918000, 0, 1, mk(ST_T3, 0, 16'h0004, B_YIN, ALU_NOP)));
        tbl.push_back(v(32'h18918000, 0, 1, mk(ST_T4, 0, 16'h0008, B_ZIN, ALU_ADD)));
        tbl.push_back(v(32'h18918000, 0, 1, mk(ST_T5, 16'h0002, 0, B_ZLO, ALU_NOP)));
        push_fetch(32'h48918000, 1'b1);
        tbl.push_back(v(32'h48918000, 1, 1, mk(ST_T3, 0, 16'h0004, B_YIN, ALU_NOP)));
        tbl.push_back(v(32'h48918000, 1, 1, mk(ST_T4, 0, 16'h0008, B_ZIN, ALU_AND)));
        tbl.push_back(v(32'h48918000, 1, 1, mk(ST_T5, 16'h0002, 0, B_ZLO, ALU_NOP)));
        tbl.push_back(v(32'h48918000, 0, 1, halt_e));
        tbl.push_back(v(32'h18918000, 1, 1, halt_e));
        tbl.push_back(v(32'h00000000, 0, 1, halt_e));

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].stop, tbl[i].e, tbl[i].ill);

        // halt instruction, then HALT held for 10 cycles regardless of Stop/IR
        do_reset();
        build(32'hD8000000);
        for (int k = 0; k < q.size(); k++) step("halt_seq", 32'hD8000000, 1'b0, q[k], 1'b0);
        for (int k = 0; k < 10; k++) step("halt_hold", $urandom(), 1'(k & 1), halt_e, 1'b0);

        // reset asserted in the middle of T1
        do_reset();
        step("mid_t0", 32'h48918000, 1'b0, mk(ST_T0, 0, 0, F0, ALU_INC), 1'b0);
        #1;
        chk_exp("mid_t1", mk(ST_T1, 0, 0, F1, ALU_NOP), 1'b0);
        #1;
        Resetn = 1'b0;
        #1;
        chk_exp("mid_rst", mk(ST_RESET, 0, 0, 0, ALU_NOP), 1'b0);
        #2;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        chk_exp("mid_restart", mk(ST_T0, 0, 0, F0, ALU_INC), 1'b0);
        @(posedge Clock);
        #1;

        // randomized instruction stream against the step-list model
        do_reset();
        model_ill = 1'b0;
        for (int n = 0; n < 300; n++) begin
            r   = $urandom();
            opc = ops[$urandom_range(0, 15)];
            ir  = {opc, r[26:0]};
            build(ir);
            last_stop = 1'b0;
            for (int k = 0; k < q.size(); k++) begin
                last_stop = ($urandom_range(0, 7) == 0);
                step("rnd", ir, last_stop, q[k], model_ill);
            end
            if (kind(opc) == 0) model_ill = 1'b1;
            if (kind(opc) == 4 || last_stop) begin
                for (int k = 0; k < 2; k++)
                    step("rnd_halt", $urandom(), 1'($urandom_range(0, 1)), halt_e, model_ill);
                do_reset();
                model_ill = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1);
    end

endmodule
